// File: rtl/sccb_seq_pkg.sv
// sccb_seq_pkg: command-entry encoding and sequencer state shared by the init sequencer and its ROM
package sccb_seq_pkg;
  typedef enum logic [1:0] {
    OP_WRITE        = 2'b00,
    OP_WRITE_VERIFY = 2'b01,
    OP_DELAY        = 2'b10,
    OP_END          = 2'b11
  } op_e;
  typedef enum logic [3:0] {
    S_IDLE, S_FETCH, S_DECODE, S_WR_REQ, S_WR_RESP,
    S_RD_REQ, S_RD_RESP, S_DELAY, S_DONE, S_ERROR
  } state_e;
  localparam int OP_HI   = 31;
  localparam int OP_LO   = 30;
  localparam int SUB_HI  = 23;
  localparam int SUB_LO  = 8;
  localparam int DATA_HI = 7;
  localparam int DATA_LO = 0;
  localparam int TICK_HI = 15;
  localparam int TICK_LO = 0;
endpackage

// File: rtl/ov5640_init_rom.sv
// ov5640_init_rom: OV5640 bring-up command table, synchronous read with one cycle of latency
module ov5640_init_rom
  import sccb_seq_pkg::*;
#(
  parameter int AW = 8
) (
  input  logic          clk,
  input  logic [AW-1:0] addr,
  output logic [31:0]   data
);
  logic [31:0] rom_d;
  always_comb begin
    case (int'(addr))
      0:       rom_d = {OP_WRITE, 6'h0, 16'h3103, 8'h11};
      1:       rom_d = {OP_WRITE, 6'h0, 16'h3008, 8'h82};
      2:       rom_d = {OP_DELAY, 14'h0, 16'd5};
      3:       rom_d = {OP_WRITE, 6'h0, 16'h3008, 8'h42};
      4:       rom_d = {OP_WRITE_VERIFY, 6'h0, 16'h4300, 8'h30};
      default: rom_d = {OP_END, 30'h0};
    endcase
  end
  always_ff @(posedge clk) data <= rom_d;
endmodule

// File: rtl/sccb_init_sequencer.sv
// sccb_init_sequencer: walks a command ROM and issues one SCCB transaction per entry,
// reporting done or error (verify exhaustion / response timeout) with the failing index.
module sccb_init_sequencer
  import sccb_seq_pkg::*;
#(
  parameter int          ROM_AW       = 8,
  parameter logic [7:0]  DEVICE_ADDR  = 8'h78,
  parameter int          DELAY_UNIT   = 50000,
  parameter int          MAX_RETRY    = 3,
  parameter int          RESP_TIMEOUT = 1000000
) (
  input  logic              clk,
  input  logic              rest,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [ROM_AW-1:0] err_index,
  output logic [ROM_AW-1:0] rom_addr,
  input  logic [31:0]       rom_data,
  output logic [7:0]        device_addr,
  output logic [15:0]       sub_addr,
  output logic              read,
  output logic              write,
  output logic [7:0]        write_data,
  input  logic              request_ready,
  input  logic [7:0]        read_data,
  input  logic              resp_valid,
  output logic              resp_ready
);
  state_e            state_q;
  op_e               op_q, dec_op;
  logic [15:0]       sub_q, ticks;
  logic [7:0]        wdata_q, retry_q;
  logic [ROM_AW-1:0] rom_addr_q, err_idx_q;
  logic [31:0]       cnt_q;
  logic              busy_q, done_q, error_q, write_q, read_q, resp_ready_q;
  logic              match, last, adv, fail, unused_rom;
  assign unused_rom = ^rom_data[29:24];
  always_comb begin
    dec_op = op_e'(rom_data[OP_HI:OP_LO]);
    ticks  = rom_data[TICK_HI:TICK_LO];
    match  = read_data == wdata_q;
    last   = &rom_addr_q;
    adv    = (state_q == S_WR_RESP && resp_valid && op_q == OP_WRITE) ||
             (state_q == S_RD_RESP && resp_valid && match) ||
             (state_q == S_DELAY && cnt_q == 32'd1) ||
             (state_q == S_DECODE && dec_op == OP_DELAY && ticks == 16'd0);
    fail   = ((state_q == S_WR_RESP || state_q == S_RD_RESP) && !resp_valid &&
              cnt_q == 32'(RESP_TIMEOUT - 1)) ||
             (state_q == S_RD_RESP && resp_valid && !match && retry_q >= 8'(MAX_RETRY));
  end
  always_ff @(posedge clk or posedge rest) begin
    if (rest) begin
      state_q      <= S_IDLE;
      op_q         <= OP_WRITE;
      sub_q        <= '0;
      wdata_q      <= '0;
      retry_q      <= '0;
      rom_addr_q   <= '0;
      err_idx_q    <= '0;
      cnt_q        <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
      write_q      <= 1'b0;
      read_q       <= 1'b0;
      resp_ready_q <= 1'b0;
    end else if (fail) begin
      state_q      <= S_ERROR;
      err_idx_q    <= rom_addr_q;
      busy_q       <= 1'b0;
      error_q      <= 1'b1;
      resp_ready_q <= 1'b0;
    end else if (adv) begin
      // the last table slot acts as an implicit END rather than wrapping to entry 0
      state_q      <= last ? S_DONE : S_FETCH;
      rom_addr_q   <= last ? rom_addr_q : rom_addr_q + ROM_AW'(1);
      busy_q       <= !last;
      done_q       <= last;
      retry_q      <= '0;
      resp_ready_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE, S_ERROR: if (start) begin
          done_q     <= 1'b0;
          error_q    <= 1'b0;
          busy_q     <= 1'b1;
          rom_addr_q <= '0;
          retry_q    <= '0;
          state_q    <= S_FETCH;
        end
        S_FETCH: state_q <= S_DECODE;
        S_DECODE: begin
          op_q    <= dec_op;
          sub_q   <= rom_data[SUB_HI:SUB_LO];
          wdata_q <= rom_data[DATA_HI:DATA_LO];
          cnt_q   <= 32'(ticks) * 32'(DELAY_UNIT);
          write_q <= dec_op == OP_WRITE || dec_op == OP_WRITE_VERIFY;
          busy_q  <= dec_op != OP_END;
          done_q  <= dec_op == OP_END;
          state_q <= dec_op == OP_END ? S_DONE : dec_op == OP_DELAY ? S_DELAY : S_WR_REQ;
        end
        S_WR_REQ: if (request_ready) begin
          write_q      <= 1'b0;
          resp_ready_q <= 1'b1;
          cnt_q        <= '0;
          state_q      <= S_WR_RESP;
        end
        S_WR_RESP: if (resp_valid) begin
          resp_ready_q <= 1'b0;
          read_q       <= 1'b1;
          state_q      <= S_RD_REQ;
        end else cnt_q <= cnt_q + 32'd1;
        S_RD_REQ: if (request_ready) begin
          read_q       <= 1'b0;
          resp_ready_q <= 1'b1;
          cnt_q        <= '0;
          state_q      <= S_RD_RESP;
        end
        S_RD_RESP: if (resp_valid) begin
          resp_ready_q <= 1'b0;
          retry_q      <= retry_q + 8'd1;
          write_q      <= 1'b1;
          state_q      <= S_WR_REQ;
        end else cnt_q <= cnt_q + 32'd1;
        S_DELAY: cnt_q <= cnt_q - 32'd1;
        default: state_q <= S_IDLE;
      endcase
    end
  end
  assign busy        = busy_q;
  assign done        = done_q;
  assign error       = error_q;
  assign err_index   = err_idx_q;
  assign rom_addr    = rom_addr_q;
  assign device_addr = DEVICE_ADDR;
  assign sub_addr    = sub_q;
  assign write_data  = wdata_q;
  assign write       = write_q;
  assign read        = read_q;
  assign resp_ready  = resp_ready_q;
endmodule

// File: tb/tb_sccb_init_sequencer.sv
// tb_sccb_init_sequencer: table vectors, directed corner sequences and random tables
// checked against a transaction-level model of the command walk.
module tb_sccb_init_sequencer;
  import sccb_seq_pkg::*;
  localparam int AW = 3, UNIT = 10, MR = 3, TO = 50;
  localparam logic [31:0] END_E = 32'hC000_0000;
  typedef logic [24:0] txn_t;
  typedef struct {
    logic [31:0] t [8];
    int lat;
    bit ok;
    bit exp_done;
    bit exp_err;
    int exp_idx;
    int nw;
    int nr;
  } vec_t;
  logic clk = 0, rst = 1, start = 0;
  logic busy, done, error, read, write, resp_ready, request_ready = 1, resp_valid;
  logic [AW-1:0] err_index, rom_addr, rom_a = '0;
  logic [31:0] rom_data, rom_q;
  logic [7:0] device_addr, write_data, read_data, last_wd;
  logic [15:0] sub_addr;
  logic [31:0] tbl [8];
  bit rd_ok [64];
  bit rr_rand = 0, resp_en = 1, rsp_rd, m_done, m_err;
  int lat = 1, rd_cnt = 0, both_cnt = 0, m_idx = 0, pass_cnt = 0, total_cnt = 0;
  txn_t log_q[$], exp_q[$];
  vec_t v [6];
  always #5 clk = ~clk;
  sccb_init_sequencer #(.ROM_AW(AW), .DELAY_UNIT(UNIT), .MAX_RETRY(MR), .RESP_TIMEOUT(TO)) dut (
    .clk(clk), .rest(rst), .start(start), .busy(busy), .done(done), .error(error),
    .err_index(err_index), .rom_addr(rom_addr), .rom_data(rom_data), .device_addr(device_addr),
    .sub_addr(sub_addr), .read(read), .write(write), .write_data(write_data),
    .request_ready(request_ready), .read_data(read_data), .resp_valid(resp_valid),
    .resp_ready(resp_ready));
  ov5640_init_rom #(.AW(AW)) urom (.clk(clk), .addr(rom_a), .data(rom_q));
  always @(posedge clk) rom_data <= tbl[rom_addr];
  always @(negedge clk) if (!rst) begin
    if (write && request_ready) log_q.push_back({1'b0, sub_addr, write_data});
    if (read && request_ready) log_q.push_back({1'b1, sub_addr, 8'h00});
    if (read && write) both_cnt++;
  end
  initial forever begin
    @(posedge clk); #1;
    if (rr_rand) request_ready = 1'($urandom_range(0, 1));
  end
  // controller stand-in: answers each accepted request after lat cycles
  initial begin
    resp_valid = 0; read_data = 0;
    forever begin
      @(negedge clk);
      if (!rst && resp_en && request_ready && (write || read)) begin
        rsp_rd = read;
        if (write) last_wd = write_data;
        repeat (lat) @(posedge clk);
        #1 resp_valid = 1;
        read_data = rsp_rd ? (rd_ok[rd_cnt % 64] ? last_wd : 8'h00) : 8'h00;
        if (rsp_rd) rd_cnt++;
        @(posedge clk); #1 resp_valid = 0;
      end
    end
  end
  initial begin
    #5_000_000;
    $display("FAIL watchdog: got no finish, expected finish");
    $fatal(1);
  end
  function automatic logic [31:0] ent(op_e op, logic [15:0] sa, logic [7:0] d);
    return {op, 6'h0, sa, d};
  endfunction
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    total_cnt++;
    if (a === e) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", n, a, e);
  endtask
  task automatic out_chk(input string tag);
    chk({tag, " ctl"}, 32'({busy, done, error, read, write, resp_ready, err_index, rom_addr}), 0);
    chk({tag, " data"}, 32'({sub_addr, write_data}), 0);
  endtask
  // expected transaction stream and outcome, derived from the table and the read outcomes
  task automatic model();
    int k = 0;
    bit ok;
    exp_q.delete(); m_done = 0; m_err = 0; m_idx = 0;
    for (int i = 0; i < 8; i++) begin
      logic [1:0] op = tbl[i][31:30];
      if (op == 2'b11) begin m_done = 1; return; end
      if (op == 2'b10) continue;
      ok = 0;
      for (int a = 0; a <= MR && !ok; a++) begin
        exp_q.push_back({1'b0, tbl[i][23:8], tbl[i][7:0]});
        if (op == 2'b00) ok = 1;
        else begin
          exp_q.push_back({1'b1, tbl[i][23:8], 8'h00});
          ok = rd_ok[k]; k++;
        end
      end
      if (!ok) begin m_err = 1; m_idx = i; return; end
    end
    m_done = 1;
  endtask
  task automatic cmp_log(input string tag);
    chk({tag, " txn count"}, log_q.size(), exp_q.size());
    for (int i = 0; i < log_q.size() && i < exp_q.size(); i++)
      chk($sformatf("%s txn%0d", tag, i), 32'(log_q[i]), 32'(exp_q[i]));
  endtask
  function automatic int count(input bit rd);
    int n = 0;
    foreach (log_q[i]) if (log_q[i][24] == rd) n++;
    return n;
  endfunction
  task automatic pulse_start();
    log_q.delete(); rd_cnt = 0;
    @(posedge clk); #1 start = 1;
    @(posedge clk); #1 start = 0;
  endtask
  task automatic run(input string tag);
    bit to = 1;
    pulse_start();
    for (int c = 0; c < 5000; c++) begin
      @(negedge clk);
      if (done || error) begin to = 0; break; end
    end
    chk({tag, " finished"}, 32'(to), 0);
  endtask
  initial begin
    int g, c, held;
    bit seen;
    foreach (tbl[i]) tbl[i] = END_E;
    foreach (v[i]) begin
      v[i].t = '{default: END_E};
      v[i].lat = 3; v[i].ok = 1; v[i].exp_done = 1; v[i].exp_err = 0; v[i].exp_idx = 0;
    end
    v[0].t[0] = ent(OP_WRITE, 16'h3008, 8'h82); v[0].lat = 5; v[0].nw = 1; v[0].nr = 0;
    v[1].t[0] = ent(OP_WRITE_VERIFY, 16'h4300, 8'h30); v[1].nw = 1; v[1].nr = 1;
    v[2].t[0] = ent(OP_WRITE_VERIFY, 16'h4300, 8'h30); v[2].ok = 0;
    v[2].exp_done = 0; v[2].exp_err = 1; v[2].nw = 4; v[2].nr = 4;
    v[3].t[0] = ent(OP_WRITE, 16'h1234, 8'h11); v[3].t[1] = {OP_DELAY, 30'h0};
    v[3].t[2] = ent(OP_WRITE_VERIFY, 16'h1235, 8'h22); v[3].t[3] = ent(OP_WRITE, 16'h1236, 8'h33);
    v[3].lat = 1; v[3].nw = 3; v[3].nr = 1;
    for (int i = 0; i < 8; i++) v[4].t[i] = ent(OP_WRITE, 16'h2000 + 16'(i), 8'(i + 1));
    v[4].nw = 8; v[4].nr = 0;
    for (int i = 0; i < 5; i++) v[5].t[i] = ent(OP_WRITE, 16'h3000 + 16'(i), 8'h40);
    v[5].t[5] = ent(OP_WRITE_VERIFY, 16'h3500, 8'hAA); v[5].ok = 0;
    v[5].exp_done = 0; v[5].exp_err = 1; v[5].exp_idx = 5; v[5].nw = 9; v[5].nr = 4;
    repeat (3) @(posedge clk);
    @(negedge clk);
    out_chk("reset");
    chk("reset dev addr", 32'(device_addr), 32'h78);
    rom_a = 3'd1;
    @(negedge clk);
    chk("rom entry1", rom_q, 32'h0030_0882);
    rom_a = 3'd7;
    @(negedge clk);
    chk("rom tail", rom_q, END_E);
    @(posedge clk); #1 rst = 0;
    for (int i = 0; i < 6; i++) begin
      tbl = v[i].t;
      foreach (rd_ok[k]) rd_ok[k] = v[i].ok;
      lat = v[i].lat; rr_rand = 0; request_ready = 1;
      run($sformatf("v%0d", i));
      model();
      chk($sformatf("v%0d done", i), 32'(done), 32'(v[i].exp_done));
      chk($sformatf("v%0d error", i), 32'(error), 32'(v[i].exp_err));
      chk($sformatf("v%0d busy", i), 32'(busy), 0);
      if (v[i].exp_err) chk($sformatf("v%0d err_index", i), 32'(err_index), 32'(v[i].exp_idx));
      chk($sformatf("v%0d writes", i), count(0), v[i].nw);
      chk($sformatf("v%0d reads", i), count(1), v[i].nr);
      if (i == 0) chk("v0 first write", 32'(log_q[0]), {7'h0, 1'b0, 16'h3008, 8'h82});
      cmp_log($sformatf("v%0d", i));
    end
    // request stall, spurious resp_valid outside a response state, then a 2-tick delay
    tbl = '{default: END_E};
    tbl[0] = ent(OP_WRITE, 16'h1111, 8'hAA); tbl[1] = {OP_DELAY, 14'h0, 16'd2};
    tbl[2] = ent(OP_WRITE, 16'h2222, 8'hBB);
    request_ready = 0; lat = 2;
    pulse_start();
    seen = 0;
    for (int k = 0; k < 20 && !seen; k++) begin @(negedge clk); seen = write; end
    chk("stall write seen", 32'(seen), 1);
    held = 0;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      if (write && !read && sub_addr == 16'h1111 && write_data == 8'hAA) held++;
      @(posedge clk); #1 resp_valid = (i == 2);
    end
    chk("stall held", held, 7);
    request_ready = 1;
    seen = 0;
    for (int k = 0; k < 100 && !seen; k++) begin @(negedge clk); seen = rom_addr == 3'd1; end
    g = 1;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (rom_addr == 3'd1) g++; else break;
    end
    chk("delay gap in 17..23", 32'(g >= 17 && g <= 23), 1);
    for (int k = 0; k < 200 && !(done || error); k++) @(negedge clk);
    chk("stall done", 32'(done), 1);
    chk("stall accepts", log_q.size(), 2);
    chk("stall first txn", 32'(log_q[0]), {7'h0, 1'b0, 16'h1111, 8'hAA});
    // response never arrives: timeout, with a start pulse ignored while busy
    tbl = '{default: END_E};
    tbl[0] = ent(OP_WRITE, 16'h3008, 8'h82);
    resp_en = 0;
    pulse_start();
    seen = 0;
    for (int k = 0; k < 20 && !seen; k++) begin @(negedge clk); seen = write && request_ready; end
    fork begin
      repeat (10) @(posedge clk); #1 start = 1;
      @(posedge clk); #1 start = 0;
    end join_none
    c = 0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk); c++;
      if (c == 20) chk("busy during timeout", 32'({busy, rom_addr}), 32'h8);
      if (error) break;
    end
    chk("timeout cycles in 47..53", 32'(c >= 47 && c <= 53), 1);
    chk("timeout error", 32'({error, done, busy}), 32'h4);
    chk("timeout err_index", 32'(err_index), 0);
    chk("timeout single write", log_q.size(), 1);
    resp_en = 1;
    // asynchronous reset while waiting in RD_RESP, then a clean rerun
    tbl = '{default: END_E};
    tbl[0] = ent(OP_WRITE_VERIFY, 16'h4300, 8'h30);
    foreach (rd_ok[k]) rd_ok[k] = 1;
    lat = 30;
    pulse_start();
    seen = 0;
    for (int k = 0; k < 200 && !seen; k++) begin @(negedge clk); seen = read && request_ready; end
    chk("reached read", 32'(seen), 1);
    repeat (3) @(negedge clk);
    #2 rst = 1;
    #1 out_chk("async reset");
    chk("async reset dev addr", 32'(device_addr), 32'h78);
    @(posedge clk); #1 rst = 0;
    repeat (40) @(posedge clk);
    lat = 2;
    run("rerun");
    model();
    chk("rerun done", 32'({done, error}), 32'h2);
    cmp_log("rerun");
    for (int r = 0; r < 20; r++) begin
      foreach (tbl[i]) begin
        int p = $urandom_range(0, 9);
        logic [15:0] sa = 16'($urandom);
        logic [7:0] d = 8'($urandom_range(1, 255));
        tbl[i] = p < 4 ? ent(OP_WRITE, sa, d) : p < 7 ? ent(OP_WRITE_VERIFY, sa, d) :
                 p < 9 ? {OP_DELAY, 14'h0, 16'($urandom_range(0, 2))} : END_E;
      end
      foreach (rd_ok[k]) rd_ok[k] = $urandom_range(0, 9) < 7;
      lat = $urandom_range(1, 4);
      rr_rand = 1;
      run($sformatf("rnd%0d", r));
      rr_rand = 0;
      #2 request_ready = 1;
      model();
      chk($sformatf("rnd%0d status", r), 32'({done, error}), 32'({m_done, m_err}));
      if (m_err) chk($sformatf("rnd%0d err_index", r), 32'(err_index), 32'(m_idx));
      cmp_log($sformatf("rnd%0d", r));
    end
    chk("read/write exclusive", both_cnt, 0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
